// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: decodes EX/MEM memory control, runs a req/ack handshake
// with variable-latency data memory, stalls the pipeline, and traps access faults.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  Mreg,
  input  logic [31:0] ALUreg,
  input  logic [31:0] WriteDataOut,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             unused_branch;

  assign access        = Mreg[1] | Mreg[0];
  assign unused_branch = Mreg[2];

  // Reset gates the IDLE term so a pending access cannot stall during reset.
  assign stall = (state == IDLE && access && reset_n) || state == ACCESS || state == ERROR;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (Mreg[1] && Mreg[0]) begin
              state    <= ERROR;
              err      <= 1'b1;
              err_code <= 2'b11;
            end else if (ALUreg[1:0] != 2'b00) begin
              state    <= ERROR;
              err      <= 1'b1;
              err_code <= 2'b01;
            end else begin
              state      <= ACCESS;
              cnt        <= '0;
              dmem_req   <= 1'b1;
              dmem_we    <= Mreg[0];
              dmem_addr  <= ALUreg;
              dmem_wdata <= WriteDataOut;
            end
          end
        end
        ACCESS: begin
          // An ack on the timeout boundary still completes the access.
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= DONE;
            if (!dmem_we) begin
              load_data  <= dmem_rdata;
              load_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            dmem_req <= 1'b0;
            state    <= ERROR;
            err      <= 1'b1;
            err_code <= 2'b10;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT = 4; expected values hand-computed.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  Mreg;
  logic [31:0] ALUreg, WriteDataOut;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, err;
  logic [1:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .Mreg(Mreg), .ALUreg(ALUreg),
    .WriteDataOut(WriteDataOut), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .err(err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    next_cycle();
    reset_n = 1'b1;
  endtask

  // Caller has set Mreg/ALUreg just after a posedge. Ack is driven in the
  // (n+1)th cycle (first ACCESS cycle is 1). Returns stall/load_valid counts.
  task automatic run_access(input int n, input logic [31:0] rdata,
                            output int stalls, output int lv, output logic [31:0] ld,
                            output logic req1, output logic we1,
                            output logic [31:0] addr1, output logic [31:0] wd1);
    bit done = 0;
    stalls = 0; lv = 0; ld = '0; req1 = 0; we1 = 0; addr1 = '0; wd1 = '0;
    for (int k = 0; k < 20; k++) begin
      dmem_ack   = (k == n + 1);
      dmem_rdata = (k == n + 1) ? rdata : 32'h0;
      @(negedge clock);
      if (stall) stalls++;
      if (load_valid) begin lv++; ld = load_data; end
      if (k == 1) begin req1 = dmem_req; we1 = dmem_we; addr1 = dmem_addr; wd1 = dmem_wdata; end
      if (!stall && k > 0) begin done = 1; break; end
      next_cycle();
    end
    dmem_ack = 1'b0;
    Mreg = 3'b000;
    chk("access_completes", 32'(done), 32'd1);
    next_cycle();
  endtask

  int stalls, lv, req_cnt;
  logic [31:0] ld, addr1, wd1;
  logic req1, we1;

  initial begin
    reset_n = 1'b0; Mreg = 3'b010; ALUreg = 32'h100; WriteDataOut = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    // Reset: every output 0, pending read ignored
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_err", {29'b0, err, err_code}, 0);
    chk("rst_load", {load_data[30:0], load_valid}, 0);
    Mreg = 3'b000;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // Stray ack while IDLE
    dmem_ack = 1'b1; dmem_rdata = 32'hAAAA5555;
    @(negedge clock);
    chk("stray_stall", 32'(stall), 0);
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clock);
    chk("stray_req", 32'(dmem_req), 0);
    chk("stray_load", load_data, 0);
    chk("stray_lv", 32'(load_valid), 0);
    next_cycle();

    // Aligned read, ack N=3 (lands on the timeout boundary: ack wins)
    Mreg = 3'b010; ALUreg = 32'h100;
    run_access(3, 32'hDEADBEEF, stalls, lv, ld, req1, we1, addr1, wd1);
    chk("rd_stalls", 32'(stalls), 5);
    chk("rd_lv_cnt", 32'(lv), 1);
    chk("rd_load", ld, 32'hDEADBEEF);
    chk("rd_req", 32'(req1), 1);
    chk("rd_we", 32'(we1), 0);
    chk("rd_addr", addr1, 32'h100);
    chk("rd_no_err", 32'(err), 0);

    // Aligned write, zero-wait ack
    Mreg = 3'b001; ALUreg = 32'h200; WriteDataOut = 32'h12345678;
    run_access(0, 32'h0BADF00D, stalls, lv, ld, req1, we1, addr1, wd1);
    chk("wr_stalls", 32'(stalls), 2);
    chk("wr_lv_cnt", 32'(lv), 0);
    chk("wr_we", 32'(we1), 1);
    chk("wr_wdata", wd1, 32'h12345678);
    chk("wr_addr", addr1, 32'h200);
    chk("wr_load_held", load_data, 32'hDEADBEEF);

    // Misaligned read
    Mreg = 3'b010; ALUreg = 32'h102;
    req_cnt = 0;
    @(negedge clock);
    chk("mis_stall0", 32'(stall), 1);
    next_cycle();
    Mreg = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (dmem_req) req_cnt++;
      next_cycle();
    end
    @(negedge clock);
    chk("mis_req_never", 32'(req_cnt), 0);
    chk("mis_err", 32'(err), 1);
    chk("mis_code", 32'(err_code), 32'h1);
    chk("mis_stall_held", 32'(stall), 1);
    do_reset();
    @(negedge clock);
    chk("mis_cleared", {29'b0, err, err_code}, 0);
    chk("mis_stall_clr", 32'(stall), 0);
    next_cycle();

    // Timeout with TIMEOUT = 4
    Mreg = 3'b010; ALUreg = 32'h300;
    req_cnt = 0;
    next_cycle();
    Mreg = 3'b000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (dmem_req) req_cnt++;
      next_cycle();
    end
    chk("to_req_cycles", 32'(req_cnt), 4);
    chk("to_code", 32'(err_code), 32'h2);
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clock);
    chk("to_late_ack_err", {29'b0, err, err_code}, 32'h6);
    chk("to_late_ack_lv", {load_data[30:0], load_valid}, 0);
    chk("to_stall", 32'(stall), 1);
    do_reset();

    // Illegal control: MemRead and MemWrite both set
    Mreg = 3'b011; ALUreg = 32'h400;
    next_cycle();
    Mreg = 3'b000;
    @(negedge clock);
    chk("ill_code", 32'(err_code), 32'h3);
    chk("ill_req", 32'(dmem_req), 0);
    chk("ill_err", 32'(err), 1);
    do_reset();

    // Reset mid-ACCESS after 2 wait cycles, then reapply read
    Mreg = 3'b010; ALUreg = 32'h500;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clock);
    chk("mid_req_pre", 32'(dmem_req), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_req_async", 32'(dmem_req), 0);
    chk("mid_stall", 32'(stall), 0);
    chk("mid_addr", dmem_addr, 0);
    next_cycle();
    reset_n = 1'b1;
    run_access(1, 32'hCAFEF00D, stalls, lv, ld, req1, we1, addr1, wd1);
    chk("mid_stalls", 32'(stalls), 3);
    chk("mid_load", ld, 32'hCAFEF00D);
    chk("mid_addr_re", addr1, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the five-stage MIPS pipeline. It decodes the memory-control bits held in the EX/MEM pipeline register, runs a req/ack handshake with a variable-latency data memory, and holds the pipeline with `stall` until the access completes. It also catches misaligned or illegal accesses and bus timeouts, and freezes the machine in an error state when one occurs.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum ACCESS cycles without ack before a bus error; legal range 1..65535.
- `CNT_W`, default 16: timeout counter width; must satisfy `TIMEOUT` < 2^`CNT_W`.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `Mreg`  in  3  EX/MEM memory control: [2] Branch (ignored here), [1] MemRead, [0] MemWrite.
- `ALUreg`  in  32  byte address from the EX/MEM register.
- `WriteDataOut`  in  32  store data from the EX/MEM register.
- `dmem_req`  out  1  memory request; registered.
- `dmem_we`  out  1  1 = write, 0 = read; registered and valid while `dmem_req` = 1.
- `dmem_addr`  out  32  latched word address; registered.
- `dmem_wdata`  out  32  latched store data; registered.
- `dmem_ack`  in  1  completion strobe, one cycle wide.
- `dmem_rdata`  in  32  read data, valid with `dmem_ack`.
- `stall`  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; combinational from state and inputs.
- `load_data`  out  32  captured read data.
- `load_valid`  out  1  high for the DONE cycle of a read.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  cause: 01 misaligned, 10 timeout, 11 MemRead and MemWrite both set.

## Operation
Definitions:
- `access` = `Mreg[1]` | `Mreg[0]`.

State machine has four states: IDLE, ACCESS, DONE, ERROR.

IDLE:
- If `access` is 0, remain in IDLE.
- If `access` is 1 and both `Mreg[1]` and `Mreg[0]` are set, go to ERROR with code 11.
- If `access` is 1 and `ALUreg[1:0]` ≠ 0, go to ERROR with code 01.
- Otherwise, latch `dmem_addr` ← `ALUreg`, `dmem_wdata` ← `WriteDataOut`, `dmem_we` ← `Mreg[0]`. Set `dmem_req` ← 1, clear the counter, go to ACCESS.

ACCESS:
- `dmem_req` stays high; address, data and we are held stable.
- On `dmem_ack` = 1:
  - drop `dmem_req`;
  - if it is a read, load `load_data` ← `dmem_rdata`;
  - go to DONE.
- With no ack, the counter increments. When counter = `TIMEOUT` − 1 and there is no ack: drop `dmem_req` and go to ERROR with code 10.
- An ack on the same cycle as the timeout boundary wins (the access completes).

DONE:
- Lasts one cycle. `stall` = 0, so EX/MEM and MEM/WB advance.
- `load_valid` = 1 for reads only.
- Always returns to IDLE. `Mreg` is ignored this cycle, because it still shows the instruction that just completed.

ERROR:
- `err` = 1, `stall` = 1, `dmem_req` = 0.
- Sticky: only `reset_n` exits this state.

General rules:
- `dmem_ack` outside ACCESS is ignored.
- `load_data` holds its last value until the next read completes.

## Timing
Reset (asynchronous, `reset_n` low), every output goes to 0:
- state ← IDLE, counter ← 0
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` = 0
- `load_data`, `load_valid` = 0
- `err`, `err_code` = 0
- `stall` = 0 (state IDLE, and `access` is ignored while reset is asserted)

`stall` equation: `stall` = (IDLE & `access`) | ACCESS | ERROR.

Latency with the ack arriving N cycles after `dmem_req` rises (N ≥ 0, ack in the first ACCESS cycle is N = 0):
- cycle 0: IDLE detects the access, `stall` = 1.
- cycles 1..N+1: ACCESS, `stall` = 1.
- cycle N+2: DONE, `stall` = 0.
- Total stall cycles per access = N + 2. Minimum is 2.

Timeout:
- ERROR is entered after exactly `TIMEOUT` ACCESS cycles with no ack.
- `err` rises on the following edge.

Back-to-back accesses:
- The DONE→IDLE transition guarantees at least one non-stalled cycle between consecutive accesses.
- The next access is detected in the IDLE cycle that follows DONE.

Reset mid-ACCESS:
- `dmem_req` drops immediately (asynchronously).
- The memory must tolerate an abandoned request.

## Test plan
- Aligned read: `Mreg` = 010, `ALUreg` = 0x100, ack 3 cycles after req with `dmem_rdata` = 0xDEADBEEF → `stall` high for 5 cycles; `load_valid` high for 1 cycle with `load_data` = 0xDEADBEEF; `dmem_we` = 0.
- Aligned write with zero-wait ack: `Mreg` = 001, `ALUreg` = 0x200, `WriteDataOut` = 0x12345678, ack in the first ACCESS cycle → `dmem_we` = 1, `dmem_wdata` = 0x12345678, `stall` for 2 cycles, `load_valid` stays 0.
- Misaligned read: `Mreg` = 010, `ALUreg` = 0x102 → no `dmem_req` ever; `err` = 1, `err_code` = 01, `stall` held high until `reset_n` is pulsed.
- Timeout: `TIMEOUT` = 4, read issued, no ack → `dmem_req` high for exactly 4 cycles, then `err_code` = 10; a late ack is ignored.
- Illegal control: `Mreg` = 011 → `err_code` = 11. Separately, a stray ack while IDLE → no state change.
- Reset during ACCESS after 2 wait cycles, then reapply the read → all outputs 0 during reset; after release, the read completes normally with 2 + N stall cycles.
